// File: rtl/mem_load_pkg.sv
// Shared state encodings and target indices for the memory load arbiter.
package mem_load_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  localparam int TGT_IMEM = 0;
  localparam int TGT_DMEM = 1;

  // Select field width, never narrower than one bit.
  function automatic int selWidth(input int numTgt);
    return (numTgt > 1) ? $clog2(numTgt) : 1;
  endfunction

endpackage

// File: rtl/load_addr_counter.sv
// Burst address and remaining-word counter for the host loader.
module load_addr_counter
  import mem_load_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] baseAdr,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] adr,
  output logic              isLast
);

  localparam logic [ADDR_W-1:0] ADR_STEP = ADDR_W'(DATA_W / 8);

  logic [LEN_W-1:0] count;

  // Address wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      adr   <= '0;
      count <= '0;
    end else if (load) begin
      adr   <= baseAdr;
      count <= len;
    end else if (step) begin
      adr   <= adr + ADR_STEP;
      count <= count - LEN_W'(1);
    end
  end

  assign isLast = (count == LEN_W'(1));

endmodule

// File: rtl/mem_load_arbiter.sv
// Arbitrates the memory write path between a host burst loader and the CPU data port.
// Define MEM_LOAD_CHECKSUM_EN to build the running checksum of loaded words.
module mem_load_arbiter
  import mem_load_pkg::*;
#(
  parameter int  ADDR_W   = 32,
  parameter int  DATA_W   = 32,
  parameter int  LEN_W    = 16,
  parameter int  NUM_TGT  = 2,
  parameter int  DATA_TGT = TGT_DMEM,
  localparam int SEL_W    = selWidth(NUM_TGT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               host_start,
  input  logic               host_go,
  input  logic [SEL_W-1:0]   host_sel,
  input  logic [ADDR_W-1:0]  host_base_adr,
  input  logic [LEN_W-1:0]   host_len,
  input  logic               host_valid,
  input  logic [DATA_W-1:0]  host_wdata,
  output logic               host_ready,
  output logic               load_done,
  output logic               load_err,
  output logic               busy,
  output logic               cpu_hold,
  input  logic               cpu_memwrite,
  input  logic [ADDR_W-1:0]  cpu_adr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic [NUM_TGT-1:0] mem_we,
  output logic [ADDR_W-1:0]  mem_adr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic [DATA_W-1:0]  checksum
);

  state_t            state, nextState;
  logic [SEL_W-1:0]  selReg;
  logic              selErr;
  logic [ADDR_W-1:0] adr;
  logic              isLast;
  logic              capture;
  logic              accept;

  assign capture = ((state == ST_IDLE) || (state == ST_RUN)) && host_start;
  // Reset blocks the same-cycle write so an aborted burst leaves memory untouched.
  assign accept  = (state == ST_LOAD) && host_valid && !reset;

  load_addr_counter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) uCounter (
    .clk     (clk),
    .reset   (reset),
    .load    (capture),
    .step    (accept),
    .baseAdr (host_base_adr),
    .len     (host_len),
    .adr     (adr),
    .isLast  (isLast)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      selReg <= '0;
      selErr <= 1'b0;
    end else begin
      state <= nextState;
      if (capture) begin
        selReg <= host_sel;
        selErr <= (int'(host_sel) >= NUM_TGT);
      end
    end
  end

  // host_start outranks host_go when both arrive together.
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: begin
        if (host_start)   nextState = (host_len == '0) ? ST_DONE : ST_LOAD;
        else if (host_go) nextState = ST_RUN;
      end
      ST_LOAD: if (accept && isLast) nextState = ST_DONE;
      ST_DONE: nextState = ST_IDLE;
      ST_RUN:  if (host_start) nextState = (host_len == '0) ? ST_DONE : ST_LOAD;
      default: nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    host_ready = 1'b0;
    load_done  = 1'b0;
    load_err   = 1'b0;
    busy       = 1'b0;
    cpu_hold   = 1'b1;
    mem_we     = '0;
    mem_adr    = adr;
    mem_wdata  = '0;
    case (state)
      ST_LOAD: begin
        host_ready = !reset;
        busy       = 1'b1;
        mem_wdata  = host_wdata;
        for (int i = TGT_IMEM; i < NUM_TGT; i++)
          mem_we[i] = accept && !selErr && (int'(selReg) == i);
      end
      ST_DONE: begin
        load_done = 1'b1;
        load_err  = selErr;
        busy      = 1'b1;
      end
      ST_RUN: begin
        cpu_hold         = 1'b0;
        mem_we[DATA_TGT] = cpu_memwrite && !reset;
        mem_adr          = cpu_adr;
        mem_wdata        = cpu_wdata;
      end
      default: ;
    endcase
  end

`ifdef MEM_LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] sum;

  always_ff @(posedge clk) begin
    if (reset || capture) sum <= '0;
    else if (accept)      sum <= sum + host_wdata;
  end

  assign checksum = sum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_load_arbiter.sv
// Scoreboard bench for mem_load_arbiter: directed bursts, CPU pass-through and edge cases.
module tb_mem_load_arbiter;
  import mem_load_pkg::*;

`ifdef MEM_LOAD_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        host_start, host_go, host_sel, host_valid;
  logic [31:0] host_base_adr, host_wdata;
  logic [15:0] host_len;
  logic        host_ready, load_done, load_err, busy, cpu_hold;
  logic        cpu_memwrite;
  logic [31:0] cpu_adr, cpu_wdata;
  logic [1:0]  mem_we;
  logic [31:0] mem_adr, mem_wdata, checksum;

  mem_load_arbiter dut (
    .clk(clk), .reset(reset), .host_start(host_start), .host_go(host_go),
    .host_sel(host_sel), .host_base_adr(host_base_adr), .host_len(host_len),
    .host_valid(host_valid), .host_wdata(host_wdata), .host_ready(host_ready),
    .load_done(load_done), .load_err(load_err), .busy(busy), .cpu_hold(cpu_hold),
    .cpu_memwrite(cpu_memwrite), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata), .checksum(checksum)
  );

  // Three-target instance so an out-of-range select is representable.
  logic        start3, valid3, ready3, done3, err3, busy3, hold3;
  logic [1:0]  sel3;
  logic [31:0] base3, wdata3, adr3, wd3, sum3;
  logic [15:0] len3;
  logic [2:0]  we3;
  logic        zeroBit;
  logic [31:0] zeroWord;

  mem_load_arbiter #(.NUM_TGT(3)) dut3 (
    .clk(clk), .reset(reset), .host_start(start3), .host_go(zeroBit),
    .host_sel(sel3), .host_base_adr(base3), .host_len(len3),
    .host_valid(valid3), .host_wdata(wdata3), .host_ready(ready3),
    .load_done(done3), .load_err(err3), .busy(busy3), .cpu_hold(hold3),
    .cpu_memwrite(zeroBit), .cpu_adr(zeroWord), .cpu_wdata(zeroWord),
    .mem_we(we3), .mem_adr(adr3), .mem_wdata(wd3), .checksum(sum3)
  );

  typedef struct packed { logic [1:0] we; logic [31:0] adr; logic [31:0] data; } wr_t;
  typedef struct packed { logic err; logic [31:0] sum; } done_t;

  wr_t         wrQ[$];
  done_t       doneQ[$];
  int          nChecks = 0;
  int          nPass = 0;
  logic [31:0] expSum;
  logic [31:0] wbuf [0:7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] expChk(input logic [31:0] s);
    return CHK_EN ? s : 32'h0;
  endfunction

  // Monitor: every presented write or done pulse must match the head of its queue.
  always @(negedge clk) begin
    wr_t   w;
    done_t d;
    if (mem_we !== 2'b00) begin
      if (wrQ.size() == 0) check("unexpected_we", 64'(mem_we), 64'(0));
      else begin
        w = wrQ.pop_front();
        check("mem_we", 64'(mem_we), 64'(w.we));
        check("mem_adr", 64'(mem_adr), 64'(w.adr));
        check("mem_wdata", 64'(mem_wdata), 64'(w.data));
      end
    end
    if (load_done !== 1'b0) begin
      if (doneQ.size() == 0) check("unexpected_done", 64'(load_done), 64'(0));
      else begin
        d = doneQ.pop_front();
        check("load_err", 64'(load_err), 64'(d.err));
        check("checksum", 64'(checksum), 64'(d.sum));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic startBurst(input logic s, input logic [31:0] base, input logic [15:0] len);
    host_start = 1'b1; host_sel = s; host_base_adr = base; host_len = len;
    step();
    host_start = 1'b0; cpu_memwrite = 1'b0; expSum = 32'h0;
  endtask

  task automatic sendWords(input logic s, input logic [31:0] base, input int n,
                           input bit gaps, input bit finishes);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + 32'(i * 4);
      wrQ.push_back('{we: (s ? 2'b10 : 2'b01), adr: a, data: wbuf[i]});
      expSum = expSum + wbuf[i];
      host_valid = 1'b1; host_wdata = wbuf[i];
      check("host_ready_load", 64'(host_ready), 64'(1));
      step();
      host_valid = 1'b0;
      if (gaps && i != n - 1) step();
    end
    if (finishes) begin
      doneQ.push_back('{err: 1'b0, sum: expChk(expSum)});
      check("done_pulse", 64'(load_done), 64'(1));
      check("done_ready", 64'(host_ready), 64'(0));
      check("done_busy", 64'(busy), 64'(1));
      check("done_hold", 64'(cpu_hold), 64'(1));
      step();
      check("idle_done_low", 64'(load_done), 64'(0));
      check("idle_busy", 64'(busy), 64'(0));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; host_start = 0; host_go = 0; host_sel = 0; host_valid = 0;
    host_base_adr = 0; host_wdata = 0; host_len = 0;
    cpu_memwrite = 0; cpu_adr = 0; cpu_wdata = 0;
    start3 = 0; valid3 = 0; sel3 = 0; base3 = 0; wdata3 = 0; len3 = 0;
    zeroBit = 0; zeroWord = 0; expSum = 0;
    wbuf = '{default: 32'h0};
    step(); step();
    check("rst_ready", 64'(host_ready), 64'(0));
    check("rst_done", 64'(load_done), 64'(0));
    check("rst_err", 64'(load_err), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_hold", 64'(cpu_hold), 64'(1));
    check("rst_we", 64'(mem_we), 64'(0));
    check("rst_adr", 64'(mem_adr), 64'(0));
    check("rst_checksum", 64'(checksum), 64'(0));
    reset = 1'b0;
    step();

    // Back-to-back burst into instruction memory.
    startBurst(1'b0, 32'h0, 16'd3);
    check("t1_hold", 64'(cpu_hold), 64'(1));
    check("t1_busy", 64'(busy), 64'(1));
    wbuf = '{0: 32'h00500113, 1: 32'h00C00193, 2: 32'hFFF00213, default: 32'h0};
    sendWords(1'b0, 32'h0, 3, 1'b0, 1'b1);

    // Burst with host_valid toggling.
    startBurst(1'b1, 32'h100, 16'd4);
    wbuf = '{0: 32'h11111111, 1: 32'h22222222, 2: 32'h33333333, 3: 32'hF0000000,
             default: 32'h0};
    sendWords(1'b1, 32'h100, 4, 1'b1, 1'b1);
    check("checksum_hold", 64'(checksum), 64'(expChk(expSum)));

    // Release CPU and pass a store through.
    host_go = 1'b1;
    step();
    host_go = 1'b0;
    check("run_hold", 64'(cpu_hold), 64'(0));
    check("run_busy", 64'(busy), 64'(0));
    cpu_memwrite = 1'b1; cpu_adr = 32'h64; cpu_wdata = 32'h19;
    wrQ.push_back('{we: 2'b10, adr: 32'h64, data: 32'h19});
    #1;
    check("run_we", 64'(mem_we), 64'(2'b10));
    step();
    cpu_memwrite = 1'b0;

    // Start from RUN with a simultaneous store, then a wrapping burst.
    cpu_memwrite = 1'b1; cpu_adr = 32'h68; cpu_wdata = 32'h2A;
    wrQ.push_back('{we: 2'b10, adr: 32'h68, data: 32'h2A});
    startBurst(1'b0, 32'hFFFFFFFC, 16'd2);
    check("t4_hold_rises", 64'(cpu_hold), 64'(1));
    wbuf = '{0: 32'hA5A5A5A5, 1: 32'h5A5A5A5A, default: 32'h0};
    sendWords(1'b0, 32'hFFFFFFFC, 2, 1'b0, 1'b1);

    // CPU store outside RUN is suppressed.
    cpu_memwrite = 1'b1; cpu_adr = 32'h70; cpu_wdata = 32'h55;
    #1;
    check("idle_cpu_we", 64'(mem_we), 64'(0));
    step();
    cpu_memwrite = 1'b0;

    // Zero-length burst.
    startBurst(1'b0, 32'h300, 16'd0);
    doneQ.push_back('{err: 1'b0, sum: 32'h0});
    check("len0_done", 64'(load_done), 64'(1));
    check("len0_we", 64'(mem_we), 64'(0));
    step();
    check("len0_idle", 64'(load_done), 64'(0));

    // Reset after two of five accepts.
    startBurst(1'b1, 32'h200, 16'd5);
    wbuf = '{0: 32'h1, 1: 32'h2, 2: 32'h3, 3: 32'h4, 4: 32'h5, default: 32'h0};
    sendWords(1'b1, 32'h200, 2, 1'b0, 1'b0);
    reset = 1'b1; host_valid = 1'b1; host_wdata = wbuf[2];
    #1;
    check("rstmid_we", 64'(mem_we), 64'(0));
    check("rstmid_ready", 64'(host_ready), 64'(0));
    step();
    reset = 1'b0;
    check("post_rst_ready", 64'(host_ready), 64'(0));
    check("post_rst_hold", 64'(cpu_hold), 64'(1));
    check("post_rst_busy", 64'(busy), 64'(0));
    step(); step();
    host_valid = 1'b0;

    // host_start and host_go together: load wins, go is dropped.
    host_go = 1'b1;
    startBurst(1'b0, 32'h40, 16'd1);
    host_go = 1'b0;
    check("sg_busy", 64'(busy), 64'(1));
    check("sg_ready", 64'(host_ready), 64'(1));
    check("sg_hold", 64'(cpu_hold), 64'(1));
    wbuf = '{0: 32'hDEADBEEF, default: 32'h0};
    sendWords(1'b0, 32'h40, 1, 1'b0, 1'b1);
    check("sg_hold_after", 64'(cpu_hold), 64'(1));

    // Out-of-range select on the three-target instance.
    start3 = 1'b1; sel3 = 2'd3; base3 = 32'h0; len3 = 16'd2;
    step();
    start3 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid3 = 1'b1; wdata3 = 32'(i + 7);
      #1;
      check("err_ready", 64'(ready3), 64'(1));
      check("err_we", 64'(we3), 64'(0));
      step();
    end
    valid3 = 1'b0;
    check("err_done", 64'(done3), 64'(1));
    check("err_flag", 64'(err3), 64'(1));
    step();
    // A valid third target still writes.
    start3 = 1'b1; sel3 = 2'd2; base3 = 32'h80; len3 = 16'd1;
    step();
    start3 = 1'b0; valid3 = 1'b1; wdata3 = 32'h77;
    #1;
    check("tgt2_we", 64'(we3), 64'(3'b100));
    check("tgt2_adr", 64'(adr3), 64'(32'h80));
    step();
    valid3 = 1'b0;
    check("tgt2_noerr", 64'(err3), 64'(0));

    step(); step(); step();
    check("wrQ_empty", 64'(wrQ.size()), 64'(0));
    check("doneQ_empty", 64'(doneQ.size()), 64'(0));
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
